// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a 3-sample mid-bit majority vote.
// Frames go out on valid/ready with parity, framing and break flags.
module uart_rx_cfg #(
  parameter int F         = 8000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_break,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);

  localparam int MOD = (F + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(MOD);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] S0   = CW'(MOD / 2 - 1);
  localparam logic [CW-1:0] S1   = CW'(MOD / 2);
  localparam logic [CW-1:0] DP   = CW'(MOD / 2 + 1);
  localparam logic [CW-1:0] WRAP = CW'(MOD - 1);

  localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t state;
  state_t state_nx;

  logic                 rx_s1;
  logic                 rs;
  logic [CW-1:0]        ctr;
  logic                 v0;
  logic                 v1;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbit;
  logic                 ferr_q;

  logic dp;
  logic maj;
  logic done;
  logic ferr_now;
  logic perr_c;
  logic brk_c;
  logic idle_cur;
  logic idle_nx;

  always_comb begin
    dp       = (ctr == DP);
    maj      = (v0 & v1) | (v0 & rs) | (v1 & rs);
    ferr_now = ferr_q | ~maj;
    done     = 1'b0;
    state_nx = state;
    unique case (state)
      WAIT_IDLE: if (rs) state_nx = IDLE;
      IDLE:      if (!rs) state_nx = START;
      START:     if (dp) state_nx = maj ? IDLE : DATA;
      DATA: begin
        if (dp && bcnt == LAST_D)
          state_nx = (PARITY != 0) ? PAR : STOP;
      end
      PAR:       if (dp) state_nx = STOP;
      STOP: begin
        if (dp && bcnt == LAST_S) begin
          done     = 1'b1;
          state_nx = ferr_now ? WAIT_IDLE : IDLE;
        end
      end
      default:   state_nx = WAIT_IDLE;
    endcase
  end

  always_comb begin
    idle_cur = (state == IDLE) || (state == WAIT_IDLE);
    idle_nx  = (state_nx == IDLE) || (state_nx == WAIT_IDLE);
    busy     = ~idle_cur;
    if (PARITY == 0)
      perr_c = 1'b0;
    else
      perr_c = (^shreg ^ pbit) ^ (PARITY == 1);
    brk_c = ferr_now & ~(|shreg) & ~pbit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1  <= 1'b1;
      rs     <= 1'b1;
      state  <= WAIT_IDLE;
      ctr    <= '0;
      v0     <= 1'b1;
      v1     <= 1'b1;
      bcnt   <= '0;
      shreg  <= '0;
      pbit   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rs    <= rx_s1;
      state <= state_nx;
      if (idle_cur || idle_nx)
        ctr <= '0;
      else if (ctr == WRAP)
        ctr <= '0;
      else
        ctr <= ctr + 1'b1;
      if (ctr == S0) v0 <= rs;
      if (ctr == S1) v1 <= rs;
      if (state == IDLE) begin
        bcnt   <= '0;
        pbit   <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (dp) begin
        unique case (state)
          DATA: begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            bcnt  <= (bcnt == LAST_D) ? '0 : bcnt + 1'b1;
          end
          PAR: pbit <= maj;
          STOP: begin
            ferr_q <= ferr_now;
            bcnt   <= bcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A finished frame loads only into a free or simultaneously drained slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_break <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_valid <= 1'b1;
        rx_data  <= shreg;
        rx_perr  <= perr_c;
        rx_ferr  <= ferr_now;
        rx_break <= brk_c;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && rx_valid && !rx_ready)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Supports configurable data width, parity and stop-bit count, and uses a 3-sample majority vote at mid-bit. Detects false starts, parity errors, framing errors, break and overrun. Presents each frame on a valid/ready output to the command/packet layer.

Parameters:
F, 8000000, system clock frequency in Hz
BAUD, 115200, line rate; bit period MOD = (F+BAUD/2)/BAUD clocks, MOD >= 8 required
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, legal 1 or 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  received data word
rx_valid  out  1  rx_data and flags valid
rx_ready  in  1  consumer accepts the word
rx_perr  out  1  parity error for the presented word (0 when PARITY=0)
rx_ferr  out  1  framing error (a stop bit sampled 0) for the presented word
rx_break  out  1  presented word is a break (ferr, data all zero, parity bit 0)
overrun  out  1  sticky: a frame completed while rx_valid=1 and not accepted
clr_overrun  in  1  clears overrun
busy  out  1  high in any state other than IDLE and WAIT_IDLE

Behaviour:
- rx passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rs.
- Bit counter ctr counts 0..MOD-1 and wraps. It is held at 0 in IDLE and WAIT_IDLE, and starts counting on the cycle after the start edge.
- Samples are taken at ctr = MOD/2-1, MOD/2 and MOD/2+1. The bit value is the majority of the three, registered at ctr = MOD/2+1 (the "decision point").
- States:
  - WAIT_IDLE: entered after reset and after any framing error. Go to IDLE when rs=1.
  - IDLE: rs=0 -> START.
  - START: at the decision point, majority 1 -> IDLE (false start, nothing output); majority 0 -> DATA.
  - DATA: one bit per decision point, shifted in LSB first. After DATA_BITS bits -> PARITY if PARITY != 0, otherwise -> STOP.
  - PARITY: capture the parity bit at the decision point. perr = XOR of data bits and parity bit, inverted for odd parity, i.e. it flags a mismatch. -> STOP.
  - STOP: STOP_BITS decision points. Any 0 sets ferr. After the last stop bit the frame completes: go to IDLE if ferr=0, or WAIT_IDLE if ferr=1.
- Frame completion happens at the last stop bit's decision point, mid-bit. This leaves margin to catch the next start bit.
- Output on completion: if rx_valid=0, or rx_valid=1 with rx_ready=1 on that same cycle, then on the next cycle rx_data, rx_perr, rx_ferr and rx_break load and rx_valid=1. Otherwise the new frame is dropped, the held word is unchanged, and overrun is set on the next cycle.
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new word loads on that same edge.
- overrun is sticky. clr_overrun clears it, but a set on the same cycle wins.
- rx_data, rx_perr, rx_ferr and rx_break are stable while rx_valid=1.
- Reset values: state WAIT_IDLE, rx_valid 0, rx_data 0, rx_perr 0, rx_ferr 0, rx_break 0, overrun 0, busy 0, ctr 0.
- Reset mid-frame aborts the frame with no output. Because the state returns to WAIT_IDLE, a line held low during reset is not decoded as a start bit.
- Line activity does not affect a word already held in rx_valid.

Test Plan:
- Defaults (MOD=69), send 0xA5 8N1 with ideal timing, rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, perr=ferr=0, rx_valid rises 1 clk after the stop bit's decision point.
- Low glitch of 20 clks on idle line -> START aborts at the decision point, no rx_valid, busy returns to 0; then a valid 0x3C frame is received correctly.
- PARITY=2, DATA_BITS=7, send 0x41 with parity bit 1 (wrong) -> rx_data=0x41, rx_perr=1. Repeat with parity bit 0 -> rx_perr=0.
- STOP_BITS=2, second stop bit 0 -> rx_ferr=1, state WAIT_IDLE. Hold rx low for 3 frame times -> exactly one word, rx_break=1, data 0x00. The next frame after the line returns high decodes normally.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Pulse clr_overrun -> 0. Assert rx_ready -> rx_valid drops next clk.
- Baud skew of ±3% on 0x55/0xAA back-to-back frames, plus a single-clock spike inside a data bit -> all bytes correct (the majority vote rejects the spike). Reset asserted mid-DATA -> no output, outputs at reset values.
